// File: rtl/memory_controller_q.sv
// In-order load/store queue feeding a single data-memory port; stores wait for the ROB
// commit point, misaligned accesses are reported without touching memory.
package memory_controller_q_pkg;
    localparam int ROB_ID_W = 5;

    typedef struct packed {
        logic                valid;
        logic                mem_inst;
        logic                l_s;
        logic [2:0]          funct3;
        logic [31:0]         rs1_v;
        logic [31:0]         rs2_v;
        logic [31:0]         ls_imm;
        logic [ROB_ID_W-1:0] rob_id_dest;
    } ls_q_entry;

    typedef struct packed {
        logic                ready;
        logic [ROB_ID_W-1:0] rob_id;
        logic [31:0]         rd_data;
    } mem_rob_data_bus;

    typedef enum logic [2:0] {
        IDLE,
        STORE_WAIT,
        REQ,
        RESP_WAIT,
        DRAIN
    } mc_state_e;
endpackage

module memory_controller_q
    import memory_controller_q_pkg::*;
#(
    parameter int ROB_DEPTH_BITS = ROB_ID_W,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  ls_q_entry                 ls_q_in1,
    output logic                      ls_q_ready,
    input  logic [ROB_DEPTH_BITS-1:0] rob_head,
    input  logic                      flush,
    output mem_rob_data_bus           mem_rob_data_o,
    output logic                      misaligned_o,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_rmask,
    output logic [3:0]                dmem_wmask,
    output logic [31:0]               dmem_wdata,
    input  logic [31:0]               dmem_rdata,
    input  logic                      dmem_resp,
    output logic                      in_flight_mem
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic                l_s;
        logic [2:0]          funct3;
        logic [31:0]         rs1_v;
        logic [31:0]         rs2_v;
        logic [31:0]         ls_imm;
        logic [ROB_ID_W-1:0] rob_id;
    } q_entry_t;

    q_entry_t            r_queue [QUEUE_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    mc_state_e           r_state;
    logic [31:0]         r_dmem_addr;
    logic [31:0]         r_dmem_wdata;
    logic [3:0]          r_dmem_rmask;
    logic [3:0]          r_dmem_wmask;

    q_entry_t            w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_misaligned;
    logic                w_rob_match;
    logic                w_go_req;
    logic [31:0]         w_addr;
    logic [1:0]          w_off;
    logic [1:0]          w_size;
    logic [3:0]          w_mask;
    logic [31:0]         w_store_data;
    logic [31:0]         w_lane;
    logic [31:0]         w_load_data;
    logic                w_wb_ready;
    logic                w_wb_mis;
    logic [ROB_ID_W-1:0] w_wb_rob_id;
    logic [31:0]         w_wb_data;

    assign w_head  = r_queue[r_rd_ptr[IDX_W-1:0]];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign w_push  = ls_q_in1.valid && ls_q_in1.mem_inst && !w_full && !flush;

    assign w_addr       = w_head.rs1_v + w_head.ls_imm;
    assign w_off        = w_addr[1:0];
    assign w_size       = w_head.funct3[1:0];
    assign w_misaligned = ((w_size == 2'b01) && w_off[0]) || (w_size[1] && (w_off != 2'b00));
    assign w_rob_match  = (rob_head == w_head.rob_id);
    // Decided one cycle ahead so the dmem request comes straight out of registers in REQ.
    assign w_go_req     = !flush && !w_empty && !w_misaligned &&
                          (((r_state == IDLE) && w_head.l_s) ||
                           ((r_state == STORE_WAIT) && w_rob_match));
    assign w_lane       = dmem_rdata >> {w_off, 3'b000};

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_mask       = 4'b1111;
        w_store_data = w_head.rs2_v;
        w_load_data  = w_lane;
        case (w_size)
            2'b00: begin
                w_mask       = 4'b0001 << w_off;
                w_store_data = {24'b0, w_head.rs2_v[7:0]} << {w_off, 3'b000};
                w_load_data  = w_head.funct3[2] ? {24'b0, w_lane[7:0]}
                                                : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                w_mask       = 4'b0011 << w_off;
                w_store_data = {16'b0, w_head.rs2_v[15:0]} << {w_off, 3'b000};
                w_load_data  = w_head.funct3[2] ? {16'b0, w_lane[15:0]}
                                                : {{16{w_lane[15]}}, w_lane[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_wb_ready  = 1'b0;
        w_wb_mis    = 1'b0;
        w_wb_rob_id = '0;
        w_wb_data   = '0;
        if (!flush) begin
            if ((r_state == IDLE) && !w_empty && w_misaligned) begin
                w_wb_ready  = 1'b1;
                w_wb_mis    = 1'b1;
                w_wb_rob_id = w_head.rob_id;
                w_wb_data   = w_addr;
            end else if ((r_state == RESP_WAIT) && dmem_resp) begin
                w_wb_ready  = 1'b1;
                w_wb_rob_id = w_head.rob_id;
                w_wb_data   = w_head.l_s ? w_load_data : 32'b0;
            end
        end
    end

    assign w_pop = w_wb_ready;

    // NOTE: queue storage has no reset; the pointers alone define which slots hold valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr[IDX_W-1:0]] <= '{l_s:    ls_q_in1.l_s,
                                              funct3: ls_q_in1.funct3,
                                              rs1_v:  ls_q_in1.rs1_v,
                                              rs2_v:  ls_q_in1.rs2_v,
                                              ls_imm: ls_q_in1.ls_imm,
                                              rob_id: ls_q_in1.rob_id_dest};
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_dmem_addr  <= '0;
            r_dmem_rmask <= '0;
            r_dmem_wmask <= '0;
            r_dmem_wdata <= '0;
        end else begin
            r_dmem_addr  <= w_go_req ? {w_addr[31:2], 2'b00} : '0;
            r_dmem_rmask <= (w_go_req && w_head.l_s) ? w_mask : '0;
            r_dmem_wmask <= (w_go_req && !w_head.l_s) ? w_mask : '0;
            r_dmem_wdata <= (w_go_req && !w_head.l_s) ? w_store_data : '0;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                // An outstanding memory response must still be absorbed before new work issues.
                if (((r_state == RESP_WAIT) || (r_state == DRAIN)) && !dmem_resp) begin
                    r_state <= DRAIN;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case (r_state)
                    IDLE: begin
                        if (!w_empty && !w_misaligned) r_state <= w_head.l_s ? REQ : STORE_WAIT;
                    end
                    STORE_WAIT: if (w_rob_match) r_state <= REQ;
                    REQ:        r_state <= RESP_WAIT;
                    RESP_WAIT,
                    DRAIN:      if (dmem_resp) r_state <= IDLE;
                    default:    r_state <= IDLE;
                endcase
            end
        end
    end

    assign ls_q_ready     = !w_full;
    assign in_flight_mem  = !w_empty || (r_state != IDLE);
    assign mem_rob_data_o = '{ready: w_wb_ready, rob_id: w_wb_rob_id, rd_data: w_wb_data};
    assign misaligned_o   = w_wb_mis;
    assign dmem_addr      = r_dmem_addr;
    assign dmem_rmask     = r_dmem_rmask;
    assign dmem_wmask     = r_dmem_wmask;
    assign dmem_wdata     = r_dmem_wdata;
endmodule

// File: tb/tb_memory_controller_q.sv
// Scoreboarded bench for memory_controller_q: expected dmem requests and ROB writebacks
// are queued with the stimulus and checked by independent responder/monitor processes.
module tb_memory_controller_q;
    import memory_controller_q_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    ls_q_entry       ls_q_in1;
    logic            ls_q_ready;
    logic [4:0]      rob_head;
    logic            flush;
    mem_rob_data_bus mem_rob_data_o;
    logic            misaligned_o;
    logic [31:0]     dmem_addr;
    logic [3:0]      dmem_rmask;
    logic [3:0]      dmem_wmask;
    logic [31:0]     dmem_wdata;
    logic [31:0]     dmem_rdata;
    logic            dmem_resp;
    logic            in_flight_mem;

    memory_controller_q #(.ROB_DEPTH_BITS(5), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ls_q_in1(ls_q_in1), .ls_q_ready(ls_q_ready),
        .rob_head(rob_head), .flush(flush), .mem_rob_data_o(mem_rob_data_o),
        .misaligned_o(misaligned_o), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .in_flight_mem(in_flight_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rob_id;
        logic [31:0] data;
        logic        mis;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    wb_t         exp_wb_q[$];
    req_t        exp_req_q[$];
    logic [31:0] rdata_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mem_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] rob, input logic [31:0] data, input logic mis);
        wb_t e;
        e.rob_id = rob;
        e.data   = data;
        e.mis    = mis;
        exp_wb_q.push_back(e);
    endtask

    task automatic expect_req(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                              input logic [31:0] wd, input logic [31:0] rdata);
        req_t r;
        r.addr  = addr;
        r.rmask = rm;
        r.wmask = wm;
        r.wdata = wd;
        exp_req_q.push_back(r);
        rdata_q.push_back(rdata);
    endtask

    // Drive one entry for a single clock edge.
    task automatic offer(input logic mi, input logic ls, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rob);
        ls_q_in1.valid       = 1'b1;
        ls_q_in1.mem_inst    = mi;
        ls_q_in1.l_s         = ls;
        ls_q_in1.funct3      = f3;
        ls_q_in1.rs1_v       = rs1;
        ls_q_in1.rs2_v       = rs2;
        ls_q_in1.ls_imm      = imm;
        ls_q_in1.rob_id_dest = rob;
        @(posedge clk);
        #1;
        ls_q_in1.valid    = 1'b0;
        ls_q_in1.mem_inst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while ((exp_wb_q.size() != 0 || in_flight_mem) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_wb_q.size() != 0 || in_flight_mem) begin
            errors++;
            $display("FAIL %s: timeout with %0d writebacks outstanding, in_flight_mem=%0b required drained",
                     name, exp_wb_q.size(), in_flight_mem);
        end
    endtask

    // Memory responder: checks each request, then answers after the hold is released.
    initial begin
        req_t        r;
        logic [31:0] bm;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr 0x%08h rmask %b wmask %b, required no request",
                             dmem_addr, dmem_rmask, dmem_wmask);
                    rd = 32'h0;
                end else begin
                    r  = exp_req_q.pop_front();
                    rd = rdata_q.pop_front();
                    bm = {{8{r.wmask[3]}}, {8{r.wmask[2]}}, {8{r.wmask[1]}}, {8{r.wmask[0]}}};
                    check("req_addr", dmem_addr, r.addr);
                    check("req_rmask", 32'(dmem_rmask), 32'(r.rmask));
                    check("req_wmask", 32'(dmem_wmask), 32'(r.wmask));
                    check("req_wdata", dmem_wdata & bm, r.wdata & bm);
                end
                while (mem_hold) @(posedge clk);
                @(posedge clk);
                #1;
                dmem_resp  = 1'b1;
                dmem_rdata = rd;
                @(posedge clk);
                #1;
                dmem_resp  = 1'b0;
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_rob_data_o.ready === 1'b1) begin
                if (exp_wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got rob_id %0d rd_data 0x%08h, required no writeback",
                             mem_rob_data_o.rob_id, mem_rob_data_o.rd_data);
                end else begin
                    e = exp_wb_q.pop_front();
                    check("wb_rob_id", 32'(mem_rob_data_o.rob_id), 32'(e.rob_id));
                    check("wb_rd_data", mem_rob_data_o.rd_data, e.data);
                    check("wb_misaligned", 32'(misaligned_o), 32'(e.mis));
                    if (e.mis) check("wb_mis_no_dmem", 32'({dmem_rmask, dmem_wmask}), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ls_q_in1   = '0;
        rob_head   = 5'd0;
        flush      = 1'b0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ls_q_ready", 32'(ls_q_ready), 32'h1);
        check("rst_in_flight", 32'(in_flight_mem), 32'h0);
        check("rst_ready", 32'(mem_rob_data_o.ready), 32'h0);
        check("rst_misaligned", 32'(misaligned_o), 32'h0);
        check("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load word; a non-memory entry in front is ignored
        expect_req(32'h0000_1004, 4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        expect_wb(5'd1, 32'hDEAD_BEEF, 1'b0);
        offer(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'h4, 5'd30);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'h4, 5'd1);
        wait_idle("lw", 50);

        // Sub-word loads from lanes 3 and 2
        expect_req(32'h0000_1000, 4'b1000, 4'b0000, 32'h0, 32'h8012_3456);
        expect_wb(5'd2, 32'hFFFF_FF80, 1'b0);
        expect_req(32'h0000_1000, 4'b1000, 4'b0000, 32'h0, 32'h8012_3456);
        expect_wb(5'd3, 32'h0000_0080, 1'b0);
        expect_req(32'h0000_1000, 4'b1100, 4'b0000, 32'h0, 32'h8001_ABCD);
        expect_wb(5'd4, 32'hFFFF_8001, 1'b0);
        expect_req(32'h0000_1000, 4'b1100, 4'b0000, 32'h0, 32'h8001_ABCD);
        expect_wb(5'd5, 32'h0000_8001, 1'b0);
        offer(1'b1, 1'b1, 3'b000, 32'h0000_1000, 32'h0, 32'h3, 5'd2);
        offer(1'b1, 1'b1, 3'b100, 32'h0000_1000, 32'h0, 32'h3, 5'd3);
        offer(1'b1, 1'b1, 3'b001, 32'h0000_1000, 32'h0, 32'h2, 5'd4);
        offer(1'b1, 1'b1, 3'b101, 32'h0000_1000, 32'h0, 32'h2, 5'd5);
        wait_idle("subword", 80);

        // Negative immediate
        expect_req(32'h0000_1008, 4'b1111, 4'b0000, 32'h0, 32'h0BAD_F00D);
        expect_wb(5'd6, 32'h0BAD_F00D, 1'b0);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_1010, 32'h0, 32'hFFFF_FFF8, 5'd6);
        wait_idle("neg_imm", 50);

        // Store held until it reaches the commit point
        rob_head = 5'd5;
        offer(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0000_1234, 32'h2, 5'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("store_held_no_dmem", 32'({dmem_rmask, dmem_wmask}), 32'h0);
            @(posedge clk);
            #1;
        end
        expect_req(32'h0000_2000, 4'b0000, 4'b1100, 32'h1234_0000, 32'h0);
        expect_wb(5'd7, 32'h0, 1'b0);
        rob_head = 5'd7;
        wait_idle("sh_commit", 50);

        // Byte store to lane 1
        rob_head = 5'd13;
        expect_req(32'h0000_2000, 4'b0000, 4'b0010, 32'h0000_AB00, 32'h0);
        expect_wb(5'd13, 32'h0, 1'b0);
        offer(1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'hFFFF_FFAB, 32'h1, 5'd13);
        wait_idle("sb", 50);
        rob_head = 5'd0;

        // Full queue with memory stalled; the fifth offer must be dropped
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_req(32'h0000_3000 + 32'(4 * i), 4'b1111, 4'b0000, 32'h0, 32'h1111_1111 * 32'(i + 1));
            expect_wb(5'(i + 1), 32'h1111_1111 * 32'(i + 1), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0, 32'(4 * i), 5'(i + 1));
        end
        @(negedge clk);
        check("full_ready_low", 32'(ls_q_ready), 32'h0);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0, 32'h10, 5'd5);
        @(negedge clk);
        check("full_still_low", 32'(ls_q_ready), 32'h0);
        mem_hold = 1'b0;
        n = 0;
        while (exp_wb_q.size() > 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("full_first_wb", 32'(exp_wb_q.size()), 32'h3);
        @(negedge clk);
        check("ready_after_pop", 32'(ls_q_ready), 32'h1);
        wait_idle("full_order", 100);

        // Flush while a load sits in RESP_WAIT; the late response must be drained silently
        mem_hold = 1'b1;
        expect_req(32'h0000_4000, 4'b1111, 4'b0000, 32'h0, 32'h5555_5555);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 5'd8);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h4, 5'd9);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h8, 5'd10);
        flush = 1'b1;
        offer(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'hC, 5'd11);
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", 32'(ls_q_ready), 32'h1);
        check("flush_drain_busy", 32'(in_flight_mem), 32'h1);
        @(posedge clk);
        #1;
        mem_hold = 1'b0;
        wait_idle("flush_drain", 30);
        check("flush_resp_used", 32'(rdata_q.size()), 32'h0);

        // Misaligned accesses report the address at once; a following aligned load proceeds
        expect_wb(5'd11, 32'h0000_1002, 1'b1);
        expect_req(32'h0000_1008, 4'b1111, 4'b0000, 32'h0, 32'hCAFE_F00D);
        expect_wb(5'd12, 32'hCAFE_F00D, 1'b0);
        expect_wb(5'd14, 32'h0000_1001, 1'b1);
        expect_wb(5'd15, 32'h0000_2006, 1'b1);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'h2, 5'd11);
        offer(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'h8, 5'd12);
        offer(1'b1, 1'b1, 3'b001, 32'h0000_1000, 32'h0, 32'h1, 5'd14);
        offer(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h6, 5'd15);
        wait_idle("misaligned", 60);

        check("req_q_empty", 32'(exp_req_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_controller_q.md
# memory_controller_q

Parametrised successor to the single-entry data-memory controller. Buffers up to `QUEUE_DEPTH` load/store entries from the load/store queue in an in-order circular buffer. Issues them one at a time to the data-memory port; stores are held until they reach the ROB commit point. Adds backpressure, pipeline flush with in-flight drain, and misaligned-access detection, and returns results to the ROB over `mem_rob_data_o`.

## Interface
- `ROB_DEPTH_BITS`, 5, width of ROB ids and `rob_head`.
- `QUEUE_DEPTH`, 4, entry count; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ls_q_in1` in `ls_q_entry`: incoming entry (`valid`, `mem_inst`, `l_s` 1=load, `funct3`, `rs1_v`, `rs2_v`, `ls_imm`, `rob_id_dest`).
- `ls_q_ready` out 1: room available; 1 iff queue not full.
- `rob_head` in `ROB_DEPTH_BITS`: ROB id of the oldest uncommitted instruction.
- `flush` in 1: squash all queued and in-flight work.
- `mem_rob_data_o` out `mem_rob_data_bus`: `ready` pulse, `rob_id`, `rd_data`.
- `misaligned_o` out 1: qualifies a `ready` pulse as an address-misaligned exception.
- `dmem_addr` out 32; `dmem_rmask` out 4; `dmem_wmask` out 4; `dmem_wdata` out 32; `dmem_rdata` in 32; `dmem_resp` in 1.
- `in_flight_mem` out 1: queue non-empty or FSM not IDLE.

## Operation
- **Push:** an entry is written at the tail when `ls_q_in1.valid && ls_q_in1.mem_inst && ls_q_ready`. Entries without `mem_inst`, or offered while full, are ignored. There is no full-queue bypass.
- **Address:** `addr = rs1_v + ls_imm`, modulo 2^32, computed for the head entry only.
- **Misaligned:** half-word access with `addr[0]=1`, or word access with `addr[1:0]≠0`.
- **FSM states:** IDLE, STORE_WAIT, REQ, RESP_WAIT, DRAIN.
- **IDLE, queue empty:** remain in IDLE.
- **IDLE, head misaligned:** same cycle, `ready=1`, `misaligned_o=1`, `rob_id` = head id, `rd_data` = `addr`. Pop head, remain in IDLE, no dmem access.
- **IDLE, head is an aligned load:** go to REQ.
- **IDLE, head is an aligned store:** go to STORE_WAIT.
- **STORE_WAIT:** go to REQ when `rob_head == head.rob_id_dest`; otherwise hold.
- **REQ (one cycle only):**
  - `dmem_addr = {addr[31:2],2'b00}`.
  - Load `rmask`: lb/lbu = `0001<<addr[1:0]`; lh/lhu = `0011<<addr[1:0]`; lw = `1111`.
  - Store `wmask`: same shifts by size. `wdata` lane-shifted: byte at `8*addr[1:0]`, half at `16*addr[1]`.
  - Next state RESP_WAIT.
  - Masks are 0 in every other state.
- **RESP_WAIT, on `dmem_resp`:** `ready=1` same cycle, `rob_id` = head id, pop head, go to IDLE.
  - Loads return `rd_data` sign- or zero-extended per funct3 from the addressed lane.
  - Stores return `rd_data` = 0.
- **Flush:** empties the queue (pointers reset) in the cycle it is sampled. A push offered in the same cycle is dropped.
  - From IDLE, STORE_WAIT or REQ: go to IDLE.
  - From RESP_WAIT without `dmem_resp` that cycle: go to DRAIN. DRAIN waits for `dmem_resp` without any writeback, then goes to IDLE.
  - From RESP_WAIT with `dmem_resp` that cycle: writeback is suppressed, go to IDLE.
  - `ready` is never asserted in a flush cycle.
- **Pointers:** `$clog2(QUEUE_DEPTH)+1` bits, wrap naturally. Full when the indices are equal and the MSBs differ. Push and pop in the same cycle are both honoured; count is unchanged.

## Timing
- **Reset (`rst_n=0` at edge):** state IDLE, queue empty, `ls_q_ready=1`. All outputs reset to 0 except `dmem_addr`/`dmem_wdata` (don't-care, driven 0). Reset mid-transaction abandons it; no drain.
- **Pushed entry:** visible at the head one cycle after the push edge.
- **Aligned load latency:** push edge → IDLE decision (+1) → REQ (+2) → RESP_WAIT. Writeback happens in the `dmem_resp` cycle, so minimum is 3 cycles after the push edge with a 0-wait memory.
- **Store:** adds ≥1 STORE_WAIT cycle.
- **Misaligned entry:** writeback in the first IDLE cycle it is at the head.
- **Handshakes:** `ready` is a single-cycle pulse; at most one writeback per cycle. The dmem request is held exactly one cycle; `dmem_resp` is only honoured in RESP_WAIT/DRAIN.

## Test plan
- **Load word:** lw with rs1=0x1000, imm=4, `dmem_rdata`=0xDEADBEEF, resp 1 cycle after REQ.
  - `dmem_addr`=0x1004, `rmask`=1111; `ready` with `rd_data`=0xDEADBEEF and the correct `rob_id`.
- **lb/lbu sub-word lanes:** addr 0x1003, rdata 0x80xxxxxx.
  - lb → 0xFFFFFF80; lbu → 0x00000080; `rmask`=1000.
- **Store held at commit point:** sh to 0x2002, rs2=0x1234, rob_id=7, `rob_head`=5 for 4 cycles then 7.
  - No dmem activity until head=7, then `wmask`=1100, `wdata[31:16]`=0x1234, `ready` on resp.
- **Full and backpressure:** push 4 loads with memory stalled.
  - `ls_q_ready`=0 after the 4th push; a 5th offer is dropped.
  - After the first resp, `ready` rises and order is preserved (rob_ids 1,2,3,4).
- **Flush during RESP_WAIT:** assert `flush` with 3 entries queued, resp arriving 3 cycles later.
  - Queue empties; FSM goes to DRAIN; no `ready` pulse on the resp; then IDLE with `in_flight_mem`=0.
- **Misaligned:** lw at 0x1002.
  - Same-cycle `ready` + `misaligned_o`, `rd_data`=0x1002, no `rmask`; the next entry proceeds normally.
